video_timing_monitor: RTL and testbench
=======================================

Name: video_timing_monitor

Overview:
- Passive checker that sits directly downstream of the test pattern generator (tpg). It consumes hs, vs, vld and rgb on the same clock.
- Measures line and frame timing, and checks that the incrementing grey pattern is intact.
- Publishes per-frame measurements, a lock indication and sticky error flags for bench and on-chip status readback.

Parameters:
PW, 8, bits per colour channel (rgb is 3*PW)
H_BITS, 12, width of horizontal measurement counters
V_BITS, 12, width of vertical measurement counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
hs  in  1  horizontal sync from generator
vs  in  1  vertical sync from generator
vld  in  1  pixel-valid from generator
rgb  in  3*PW  pixel {r,g,b}
clr  in  1  synchronous clear of sticky error flags and pixel-sequence history
h_total  out  H_BITS  clocks between consecutive hs rising edges
h_sync  out  H_BITS  hs high width in clocks
h_active  out  H_BITS  vld cycles in the last active line
v_total  out  V_BITS  hs rising edges per frame
v_active  out  V_BITS  lines with at least one vld cycle per frame
meas_valid  out  1  one-cycle pulse when frame measurements update
locked  out  1  two consecutive frames measured identical
err_line  out  1  sticky: line length or active width changed while locked
err_frame  out  1  sticky: lock lost
err_pix  out  1  sticky: channel mismatch or sequence break

Behaviour:
- Reset is asynchronous and active-high. All outputs, counters and the input register reset to 0; the state machine resets to SEARCH.
- Inputs hs/vs/vld/rgb are registered once. Edges are detected on the registered copy:
  - hs_rise = hs_r & ~hs_r_d
  - hs_fall = ~hs_r & hs_r_d
  - vs_rise defined the same way as hs_rise.
- Line counter hc:
  - Loads 1 on hs_rise, else increments.
  - Saturates at all-ones; no wrap.
  - On hs_rise, line_len = hc (prior value) is captured, provided a previous hs_rise occurred since reset.
- Sync width: counts cycles with hs_r=1. Latched into h_sync on hs_fall.
- Active counter ac:
  - Counts vld_r cycles and clears on hs_rise.
  - On hs_rise with ac!=0: line_act = ac is captured and va (active line count) increments.
- Line count vc: increments on hs_rise, saturating.
- Simultaneous hs_rise and vs_rise: the line closes first and is counted into the ending frame; then the frame is published; then vc/va clear to 0.
- State machine:
  - SEARCH: wait for the first vs_rise, then go to ALIGN. No publish.
  - ALIGN: on each vs_rise, publish. If the published values equal the previous published values (h_total, h_active, v_total, v_active), go to LOCKED.
  - LOCKED: on each vs_rise, publish. On any mismatch, go to ALIGN and set err_frame.
- Publish:
  - Register update of h_total=line_len, h_active=line_act, v_total=vc(+1 if simultaneous hs_rise), v_active=va.
  - meas_valid pulses for exactly one cycle.
  - Latency: outputs and meas_valid become visible 2 clk after vs is first sampled high at the input pins.
- locked is 1 exactly in LOCKED.
- err_line: set in LOCKED when a captured line_len != h_total, or a nonzero line_act != h_active.
- Pixel check, on every vld_r cycle:
  - Sets err_pix if r!=g or g!=b.
  - If a previous vld pixel has been seen since reset/clr, sets err_pix if r != prev_r+1 modulo 2^PW. Wrap 0xFF->0x00 is legal at PW=8.
  - The sequence spans lines and frames.
  - err_pix is not set on the first pixel.
- clr: clears err_line, err_frame and err_pix, and forgets prev pixel. Measurements and state are unaffected. If clr and an error condition occur in the same cycle, the error wins.
- Reset mid-frame: the machine returns to SEARCH; the partial frame is discarded.

Test Plan:
- Drive 3 frames: line period 21 clk, hs high 3 clk, 10 vld per line on lines 3..7, 12 lines per frame. Required response:
  - meas_valid pulses once per frame.
  - Outputs h_total=21, h_sync=3, h_active=10, v_total=12, v_active=5.
  - locked=1 after the 2nd published frame.
  - No errors.
- While locked, stretch one line to 22 clk -> err_line=1, locked stays 1. The next frame publishes v_total unchanged and h_total=21 (last line) -> still locked.
- Change frame to 13 lines -> err_frame=1 and locked=0 at that publish. Relock after 2 matching 13-line frames: v_total=13.
- rgb sequence 0xFE,0xFF,0x00,0x01 across a line boundary -> err_pix stays 0. Injecting g=0x05 with r=b=0x04 -> err_pix=1. clr pulse -> err_pix=0, and the next pixel (any value) raises no error.
- hs_rise and vs_rise in the same cycle -> the final line is counted: v_total=12 (not 11), and vc restarts at 0.
- Assert rst mid-frame for 1 clk -> all outputs 0 immediately (async). The first publish appears only after 2 further vs_rise (SEARCH then ALIGN).

Source files
------------

// File: rtl/video_timing_monitor.sv
// Passive checker behind the test pattern generator: measures line/frame timing,
// tracks frame-to-frame lock and verifies the incrementing grey pixel sequence.
`timescale 1ns/1ps
module video_timing_monitor #(
  parameter int PW     = 8,
  parameter int H_BITS = 12,
  parameter int V_BITS = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hs,
  input  logic              vs,
  input  logic              vld,
  input  logic [3*PW-1:0]   rgb,
  input  logic              clr,
  output logic [H_BITS-1:0] h_total,
  output logic [H_BITS-1:0] h_sync,
  output logic [H_BITS-1:0] h_active,
  output logic [V_BITS-1:0] v_total,
  output logic [V_BITS-1:0] v_active,
  output logic              meas_valid,
  output logic              locked,
  output logic              err_line,
  output logic              err_frame,
  output logic              err_pix
);

  // state  | meaning
  // SEARCH | waiting for the first frame boundary, nothing published
  // ALIGN  | publishing frames, waiting for two identical frames in a row
  // LOCKED | publishing frames, timing stable; line and frame changes flagged
  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} vtmState;

  localparam logic [H_BITS-1:0] H_ONE = H_BITS'(1);

  vtmState state, stateNext;

  logic            hsR, vsR, vldR, hsRD, vsRD;
  logic [3*PW-1:0] rgbR;
  logic            hsRise, hsFall, vsRise;

  logic [H_BITS-1:0] hc, syncCnt, ac, lineLen, lineAct;
  logic              hsSeen;
  logic [V_BITS-1:0] vc, va, vcNext, vaNext, snapTotal, snapActive;
  logic              pubPend;

  logic [PW-1:0] pixR, pixG, pixB, prevR, prevNext;
  logic          prevValid, pixBad, lineErr;
  logic          frameMatch, publish, setErrFrame;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsR  <= 1'b0;
      vsR  <= 1'b0;
      vldR <= 1'b0;
      rgbR <= '0;
      hsRD <= 1'b0;
      vsRD <= 1'b0;
    end else begin
      hsR  <= hs;
      vsR  <= vs;
      vldR <= vld;
      rgbR <= rgb;
      hsRD <= hsR;
      vsRD <= vsR;
    end
  end

  assign hsRise = hsR & ~hsRD;
  assign hsFall = ~hsR & hsRD;
  assign vsRise = vsR & ~vsRD;

  // A line closing in the same cycle as vs still belongs to the ending frame.
  assign vcNext = (hsRise && vc != '1) ? vc + 1'b1 : vc;
  assign vaNext = (hsRise && ac != '0 && va != '1) ? va + 1'b1 : va;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hc      <= '0;
      ac      <= '0;
      lineLen <= '0;
      lineAct <= '0;
      hsSeen  <= 1'b0;
    end else if (hsRise) begin
      hc     <= H_ONE;
      hsSeen <= 1'b1;
      if (hsSeen) lineLen <= hc;
      if (ac != '0) lineAct <= ac;
      ac <= vldR ? H_ONE : '0;
    end else begin
      if (hc != '1) hc <= hc + 1'b1;
      if (vldR && ac != '1) ac <= ac + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      syncCnt <= '0;
      h_sync  <= '0;
    end else begin
      if (hsRise) syncCnt <= H_ONE;
      else if (hsR && syncCnt != '1) syncCnt <= syncCnt + 1'b1;
      if (hsFall) h_sync <= syncCnt;
    end
  end

  // Frame totals are snapshotted at vs so the counters can restart immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vc         <= '0;
      va         <= '0;
      snapTotal  <= '0;
      snapActive <= '0;
      pubPend    <= 1'b0;
    end else begin
      pubPend <= vsRise;
      if (vsRise) begin
        snapTotal  <= vcNext;
        snapActive <= vaNext;
        vc         <= '0;
        va         <= '0;
      end else begin
        vc <= vcNext;
        va <= vaNext;
      end
    end
  end

  assign frameMatch = (lineLen == h_total) && (lineAct == h_active) &&
                      (snapTotal == v_total) && (snapActive == v_active);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SEARCH;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext   = state;
    publish     = 1'b0;
    setErrFrame = 1'b0;
    case (state)
      SEARCH: if (pubPend) stateNext = ALIGN;
      ALIGN: begin
        if (pubPend) begin
          publish = 1'b1;
          if (frameMatch) stateNext = LOCKED;
        end
      end
      LOCKED: begin
        if (pubPend) begin
          publish = 1'b1;
          if (!frameMatch) begin
            stateNext   = ALIGN;
            setErrFrame = 1'b1;
          end
        end
      end
      default: stateNext = SEARCH;
    endcase
  end

  assign locked = (state == LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_total    <= '0;
      h_active   <= '0;
      v_total    <= '0;
      v_active   <= '0;
      meas_valid <= 1'b0;
    end else begin
      meas_valid <= publish;
      if (publish) begin
        h_total  <= lineLen;
        h_active <= lineAct;
        v_total  <= snapTotal;
        v_active <= snapActive;
      end
    end
  end

  assign pixR     = rgbR[3*PW-1:2*PW];
  assign pixG     = rgbR[2*PW-1:PW];
  assign pixB     = rgbR[PW-1:0];
  assign prevNext = prevR + 1'b1;
  assign pixBad   = vldR && ((pixR != pixG) || (pixG != pixB) ||
                             (prevValid && (pixR != prevNext)));

  assign lineErr = hsRise && (state == LOCKED) &&
                   ((hsSeen && (hc != h_total)) || ((ac != '0) && (ac != h_active)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prevR     <= '0;
      prevValid <= 1'b0;
    end else if (vldR) begin
      prevR     <= pixR;
      prevValid <= 1'b1;
    end else if (clr) begin
      prevValid <= 1'b0;
    end
  end

  // A new error in the clr cycle survives the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_line  <= 1'b0;
      err_frame <= 1'b0;
      err_pix   <= 1'b0;
    end else begin
      err_line  <= (err_line  & ~clr) | lineErr;
      err_frame <= (err_frame & ~clr) | setErrFrame;
      err_pix   <= (err_pix   & ~clr) | pixBad;
    end
  end

endmodule

// File: tb/tb_video_timing_monitor.sv
// Directed bench for video_timing_monitor: frames of 21-clk lines, published
// measurements checked against a queue of expected frame results.
`timescale 1ns/1ps
module tb_video_timing_monitor;
  localparam int PW = 8;
  localparam int HB = 12;
  localparam int VB = 12;

  logic            clk = 1'b0;
  logic            rst, hs, vs, vld, clr;
  logic [3*PW-1:0] rgb;
  logic [HB-1:0]   h_total, h_sync, h_active;
  logic [VB-1:0]   v_total, v_active;
  logic            meas_valid, locked, err_line, err_frame, err_pix;

  typedef struct packed {
    logic [11:0] hT;
    logic [11:0] hA;
    logic [11:0] vT;
    logic [11:0] vA;
    logic        lk;
    logic        eL;
    logic        eF;
    logic        eP;
  } expT;

  expT sbq[$];
  int  nComp = 0;
  int  nFail = 0;

  logic [PW-1:0] pixVal;
  logic          mdlErrPix;
  int            stretchLine, injLine, injIdx, rstLine;
  int            seedLineA, seedLineB;
  logic [PW-1:0] seedValA, seedValB;

  always #5 clk = ~clk;

  video_timing_monitor #(.PW(PW), .H_BITS(HB), .V_BITS(VB)) dut (
    .clk(clk), .rst(rst), .hs(hs), .vs(vs), .vld(vld), .rgb(rgb), .clr(clr),
    .h_total(h_total), .h_sync(h_sync), .h_active(h_active),
    .v_total(v_total), .v_active(v_active), .meas_valid(meas_valid),
    .locked(locked), .err_line(err_line), .err_frame(err_frame), .err_pix(err_pix)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nComp++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int hT, input int hA, input int vT, input int vA,
                      input logic lk, input logic eL, input logic eF, input logic eP);
    expT e;
    e.hT = 12'(hT);
    e.hA = 12'(hA);
    e.vT = 12'(vT);
    e.vA = 12'(vA);
    e.lk = lk;
    e.eL = eL;
    e.eF = eF;
    e.eP = eP;
    sbq.push_back(e);
  endtask

  task automatic clear_knobs();
    stretchLine = -1;
    injLine     = -1;
    injIdx      = -1;
    rstLine     = -1;
    seedLineA   = -1;
    seedLineB   = -1;
  endtask

  // vs and hs rise together at the start of line 0; lines 3..7 carry 10 pixels.
  task automatic drive_frame(input int nLines, input bit expPub);
    for (int ln = 0; ln < nLines; ln++) begin
      int len;
      len = (ln == stretchLine) ? 22 : 21;
      for (int c = 0; c < len; c++) begin
        hs  = (c < 3);
        vs  = (ln == 0) && (c < 3);
        vld = (ln >= 3) && (ln <= 7) && (c >= 6) && (c < 16);
        clr = 1'b0;
        rgb = '0;
        if (c == 18 && (ln == seedLineA || ln == seedLineB)) begin
          clr       = 1'b1;
          mdlErrPix = 1'b0;
          pixVal    = (ln == seedLineA) ? seedValA : seedValB;
        end
        if (vld) begin
          rgb = {pixVal, pixVal, pixVal};
          if (ln == injLine && (c - 6) == injIdx) begin
            rgb[15:8] = pixVal + 8'd1;
            mdlErrPix = 1'b1;
          end
          pixVal = pixVal + 8'd1;
        end
        if (ln == rstLine && c == 10) begin
          rst = 1'b1;
          #1;
          chk("async_rst_hT_hS", {h_total, h_sync}, 0);
          chk("async_rst_hA_vT", {h_active, v_total}, 0);
          chk("async_rst_vA_flags", {v_active, meas_valid, locked, err_line, err_frame, err_pix}, 0);
          mdlErrPix = 1'b0;
        end
        tick();
        if (rst) rst = 1'b0;
        if (ln == 0 && c == 1) chk("meas_valid_early", meas_valid, 0);
        if (ln == 0 && c == 2) chk("meas_valid_latency", meas_valid, expPub);
      end
      chk("err_pix_line", err_pix, mdlErrPix);
    end
    clear_knobs();
  endtask

  always @(negedge clk) begin : monitor
    expT e;
    if (meas_valid) begin
      chk("meas_valid_expected", sbq.size() != 0, 1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("h_total", h_total, e.hT);
        chk("h_active", h_active, e.hA);
        chk("v_total", v_total, e.vT);
        chk("v_active", v_active, e.vA);
        chk("locked_pub", locked, e.lk);
        chk("err_line_pub", err_line, e.eL);
        chk("err_frame_pub", err_frame, e.eF);
        chk("err_pix_pub", err_pix, e.eP);
      end
    end
  end

  initial begin
    rst = 1'b1; hs = 1'b0; vs = 1'b0; vld = 1'b0; clr = 1'b0; rgb = '0;
    pixVal = '0; mdlErrPix = 1'b0;
    seedValA = '0; seedValB = '0;
    clear_knobs();
    repeat (3) tick();
    chk("reset_hT_hS", {h_total, h_sync}, 0);
    chk("reset_hA_vT", {h_active, v_total}, 0);
    chk("reset_vA_flags", {v_active, meas_valid, locked, err_line, err_frame, err_pix}, 0);
    rst = 1'b0;
    repeat (4) tick();

    drive_frame(12, 0);                                    // F0: SEARCH -> ALIGN
    chk("h_sync", h_sync, 3);
    chk("locked_f0", locked, 0);

    push(21, 10, 12, 5, 0, 0, 0, 0); drive_frame(12, 1);   // F1 publishes F0
    push(21, 10, 12, 5, 1, 0, 0, 0); drive_frame(12, 1);   // F2 publishes F1, locks
    push(21, 10, 12, 5, 1, 0, 0, 0);
    stretchLine = 5;                 drive_frame(12, 1);   // F3 with one 22-clk line
    chk("err_line_stretch", err_line, 1);
    chk("locked_stretch", locked, 1);
    chk("err_frame_stretch", err_frame, 0);

    push(21, 10, 12, 5, 1, 1, 0, 0); drive_frame(13, 1);   // F4: 13 lines
    push(21, 10, 13, 5, 0, 1, 1, 0); drive_frame(13, 1);   // F5: lock lost on F4
    push(21, 10, 13, 5, 1, 1, 1, 0);                       // F6: relocked on F5
    seedLineA = 1; seedValA = 8'hF6;  drive_frame(13, 1);  // FE,FF | 00,01 across lines 3/4
    push(21, 10, 13, 5, 1, 0, 0, 0);
    seedLineA = 1; seedValA = 8'h00; injLine = 3; injIdx = 4;
    seedLineB = 5; seedValB = 8'h80;  drive_frame(13, 1);  // F7: g=05 with r=b=04, then clr
    push(21, 10, 13, 5, 1, 0, 0, 0); drive_frame(12, 1);   // F8: back to 12 lines
    push(21, 10, 12, 5, 0, 0, 1, 0); drive_frame(12, 1);   // F9
    push(21, 10, 12, 5, 1, 0, 1, 0);
    rstLine = 5;                     drive_frame(12, 1);   // F10: reset mid-frame
    drive_frame(12, 0);                                    // F11: SEARCH -> ALIGN
    push(21, 10, 12, 5, 0, 0, 0, 0); drive_frame(12, 1);   // F12 publishes F11

    hs = 1'b0; vs = 1'b0; vld = 1'b0; clr = 1'b0; rgb = '0;
    repeat (10) tick();
    chk("scoreboard_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComp, nFail);
    $finish;
  end

endmodule
